// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 word mux, feeding a one-entry
// valid/ready output buffer, with a wrapping count of completed captures.
//
// state | meaning
// EMPTY | output buffer holds no word; any request is captured
// FULL  | output buffer holds out_data; capture only alongside a drain
module rr_mux4_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q;
  logic [1:0]       win;
  logic             any_req;
  logic             load;
  logic             drain;
  logic [WIDTH-1:0] mux_out;

  // First requester at or after the priority pointer, wrapping modulo 4.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign any_req   = |req;
  assign win       = pick_winner(req, ptr_q);
  assign out_valid = (state_q == FULL);
  assign load      = any_req & (~out_valid | out_ready) & ~reset;
  assign drain     = out_valid & out_ready;

  always_comb begin
    ack = 4'b0000;
    sel = ptr_q;
    if (reset) begin
      sel = 2'd0;
    end else begin
      if (any_req) sel = win;
      if (load)    ack[win] = 1'b1;
    end
  end

  always_comb begin
    mux_out = data0;
    case (sel)
      2'd0:    mux_out = data0;
      2'd1:    mux_out = data1;
      2'd2:    mux_out = data2;
      2'd3:    mux_out = data3;
      default: mux_out = data0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (drain && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // out_data deliberately holds its last word after a drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      ptr_q      <= 2'd0;
      xfer_count <= '0;
    end else if (load) begin
      out_data   <= mux_out;
      ptr_q      <= win + 2'd1;
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/rr_mux4_arbiter.md
# rr_mux4_arbiter

Round-robin arbiter that shares one 4:1 32-bit word multiplexer between four requesters and registers the selected word into a single-entry output buffer. Each requester uses a req/ack handshake, and the consumer uses a valid/ready handshake. The block drives the mux4 address, owns the output register, and keeps a transfer counter. It sits between producer units and a single downstream consumer, such as a register-file write port or a memory bus.

## Interface
- WIDTH, 32, data word width; matches the mux4 data path.
- CNT_W, 16, width of the transfer counter.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  req[i] high: requester i offers data_i.
- data0..data3  in  WIDTH each  requester words; mux4 inputs 0..3.
- ack  out  4  combinational one-hot; ack[i] high means data_i is captured at this edge.
- sel  out  2  combinational mux4 address (winner index).
- out_valid  out  1  registered; the output buffer holds a word.
- out_data  out  WIDTH  registered buffered word.
- out_ready  in  1  consumer accepts out_data when out_valid is also high.
- xfer_count  out  CNT_W  registered count of completed captures; wraps.

## Operation
- State is held in out_valid (EMPTY=0, FULL=1), the priority pointer ptr[1:0], out_data and xfer_count.
- Capture condition: load = (|req) & (!out_valid | out_ready).
- Winner: the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3, mod 4.
- sel = winner when |req; otherwise sel = ptr.
- out_data loads mux4(sel, data0..3), so the captured word is data_winner.
- ack = onehot(winner) when load; otherwise 4'b0000. At most one ack bit is ever high.
- On a load edge:
  - out_data <= data_winner.
  - out_valid <= 1.
  - ptr <= (winner+1) mod 4.
  - xfer_count <= xfer_count+1, wrapping from 2^CNT_W-1 to 0.
- On an edge where out_valid & out_ready & !load: out_valid <= 0. out_data keeps its last value.
- On an edge with no load and no drain: all registers hold.
- Requester rules:
  - Hold req[i] and keep data_i stable until ack[i] is seen.
  - Deassert req[i], or present the next word, in the cycle after ack[i].
  - Dropping req without an ack is allowed; no capture occurs for that request.
- Fairness: a continuously requesting requester waits at most 3 captures between grants.
- Back-to-back: drain and capture on the same edge when out_valid & out_ready & |req. Sustained throughput is 1 word/cycle.
- Reset, asynchronous and active high, at any time including mid-handshake:
  - out_valid=0, out_data=0, ptr=0, xfer_count=0.
  - ack is forced to 0 and sel to 0 while reset is high.
  - An in-flight word is discarded.

## Timing
- Latency: req[i] high with the buffer EMPTY → ack[i] in the same cycle → out_valid=1 and out_data=data_i after the next rising edge.
- Capture into a FULL buffer happens only in a cycle with out_ready=1. Otherwise ack stays 0 and the requesters stall.
- out_valid, once high, stays high and out_data stays stable until an out_ready cycle completes the drain. This is a valid/ready no-retract guarantee.
- ack and sel are combinational from req, ptr, out_valid, out_ready and reset. There is no combinational path from data* to any control output.
- ptr advances only on load edges.

## Test plan
- Reset/idle:
  - Stimulus: assert reset mid-cycle with req=4'b1111 and out_valid=1.
  - Required response: out_valid, out_data, ptr, xfer_count and ack are all 0 immediately (asynchronously).
  - After release with req=0: nothing changes for 5 cycles.
- Single transfer:
  - Stimulus: data2=32'hDEADBEEF, req=4'b0100, out_ready=1, buffer EMPTY.
  - Required response: ack=4'b0100 and sel=2 that cycle. Next edge: out_valid=1, out_data=32'hDEADBEEF, xfer_count=1.
- Round-robin:
  - Stimulus: req=4'b1111 held, out_ready=1, data_i=i+1.
  - Required response: grant order 0,1,2,3,0; out_data sequence 1,2,3,4,1 on consecutive cycles (1 word/cycle).
- Backpressure:
  - Stimulus: out_ready=0 with the buffer FULL holding 32'h5, req=4'b0010.
  - Required response: ack=0 and out_data held at 32'h5 for 4 cycles. When out_ready rises: ack=4'b0010 that cycle and out_data=data1 next edge.
- Drain without refill:
  - Stimulus: FULL, out_ready=1, req=0.
  - Required response: out_valid=0 next edge; out_data unchanged; xfer_count unchanged.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 transfers.
  - Required response: xfer_count=1 after the 17th transfer.
